// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative shift-add multiply / restoring divide unit with HI/LO result registers
// One iteration per RUN cycle on operand magnitudes; FIX applies signs and commits HI/LO.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  // {p_hi,p_lo} is the product/shift register for multiply and the remainder/quotient pair for divide.
  always_comb begin
    a_neg   = ~op[0] & a[WIDTH-1];
    b_neg   = ~op[0] & b[WIDTH-1];
    mag_a   = a_neg ? -a : a;
    mag_b   = b_neg ? -b : b;
    sum     = {1'b0, p_hi} + {1'b0, opnd};
    shifted = {p_hi, p_lo[WIDTH-1]};
    ge      = shifted >= {1'b0, opnd};
    nxt_hi  = p_hi;
    nxt_lo  = p_lo;
    if (is_div) begin
      nxt_hi = ge ? (shifted[WIDTH-1:0] - opnd) : shifted[WIDTH-1:0];
      nxt_lo = {p_lo[WIDTH-2:0], ge};
    end else if (p_lo[0]) begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], p_lo[WIDTH-1:1]};
    end else begin
      nxt_hi = {1'b0, p_hi[WIDTH-1:1]};
      nxt_lo = {p_hi[0], p_lo[WIDTH-1:1]};
    end
    prod = {p_hi, p_lo};
    if (neg_q) prod = -prod;
    quo = neg_q ? -p_lo : p_lo;
    rem = neg_r ? -p_hi : p_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      dbz      <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      opnd     <= '0;
      p_hi     <= '0;
      p_lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= op[1] && (b == '0);
            a_raw    <= a;
            cnt      <= '0;
            busy     <= 1'b1;
            p_hi     <= '0;
            p_lo     <= op[1] ? mag_a : mag_b;
            opnd     <= op[1] ? mag_b : mag_a;
            state    <= (op[1] && (b == '0)) ? FIX : RUN;
          end
        end
        RUN: begin
          p_hi <= nxt_hi;
          p_lo <= nxt_lo;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (div_zero) begin
            hi  <= a_raw;
            lo  <= '1;
            dbz <= 1'b1;
          end else if (is_div) begin
            hi  <= rem;
            lo  <= quo;
            dbz <= 1'b0;
          end else begin
            hi  <= prod[2*WIDTH-1:WIDTH];
            lo  <= prod[WIDTH-1:0];
            dbz <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
